// File: rtl/multi_edge_detector_if.sv
// rtl/multi_edge_detector_if.sv - pin, mode, clear and status bundle for multi_edge_detector
interface multi_edge_detector_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       in_sig;
  logic [2*NCH-1:0]     mode;
  logic [NCH-1:0]       clr;
  logic                 cnt_clr;
  logic [NCH-1:0]       filt_out;
  logic [NCH-1:0]       rise_pulse;
  logic [NCH-1:0]       fall_pulse;
  logic [NCH-1:0]       event_flag;
  logic [NCH*CNT_W-1:0] edge_cnt;
  logic                 irq;

  modport master (
    output in_sig, mode, clr, cnt_clr,
    input  filt_out, rise_pulse, fall_pulse, event_flag, edge_cnt, irq
  );

  modport slave (
    input  in_sig, mode, clr, cnt_clr,
    output filt_out, rise_pulse, fall_pulse, event_flag, edge_cnt, irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - per-channel sync, glitch filter, edge pulses, sticky flags and counters
module multi_edge_detector #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multi_edge_detector_if.slave     bus
);
  logic [NCH-1:0]   s;
  logic [NCH-1:0]   f;
  logic [NCH-1:0]   p;
  logic [NCH-1:0]   rise_q;
  logic [NCH-1:0]   fall_q;
  logic [NCH-1:0]   flag_q;
  logic [NCH-1:0]   mode_rise;
  logic [NCH-1:0]   mode_fall;
  logic [NCH-1:0]   q;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q [NCH];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.in_sig;
    end else begin : g_sync
      logic [NCH-1:0] chain [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '0;
        end else begin
          chain[0] <= bus.in_sig;
          for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
        end
      end
      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  // A level change is accepted only after FILT_CYCLES consecutive disagreeing samples.
  generate
    if (FILT_CYCLES == 0) begin : g_nofilt
      assign f = s;
    end else begin : g_filt
      localparam int FC_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
      localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);
      logic [FC_W-1:0] fc [NCH];
      logic [NCH-1:0]  f_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          f_q <= '0;
          for (int i = 0; i < NCH; i++) fc[i] <= '0;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (s[i] == f_q[i]) begin
              fc[i] <= '0;
            end else if (fc[i] == FC_LAST) begin
              f_q[i] <= s[i];
              fc[i]  <= '0;
            end else begin
              fc[i] <= fc[i] + 1'b1;
            end
          end
        end
      end
      assign f = f_q;
    end
  endgenerate

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < NCH; i++) begin
      mode_rise[i] = bus.mode[2*i];
      mode_fall[i] = bus.mode[2*i+1];
    end
  end

  assign q = (rise_q & mode_rise) | (fall_q & mode_fall);

  // Set beats clear on the flag, and an edge coincident with cnt_clr still counts as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      rise_q <= '0;
      fall_q <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      p      <= f;
      rise_q <= f & ~p;
      fall_q <= ~f & p;
      flag_q <= q | (flag_q & ~bus.clr);
      irq_q  <= |flag_q;
      for (int i = 0; i < NCH; i++) begin
        if (bus.cnt_clr) begin
          cnt_q[i] <= CNT_W'(q[i]);
        end else if (q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign bus.filt_out   = f;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.event_flag = flag_q;
  assign bus.irq        = irq_q;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
      assign bus.edge_cnt[CNT_W*gi +: CNT_W] = cnt_q[gi];
    end
  endgenerate
endmodule
